ncc_mem_arbiter: RTL and testbench

NCC_MEM_ARBITER -- requirements
Module: ncc_mem_arbiter

---
 rtl/ncc_mem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_ncc_mem_arbiter.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ncc_mem_arbiter.sv
// ncc_mem_arbiter: grants one of three requesters (T template read, W window read,
// R result write) access to a shared single-port memory, one burst at a time.
// Build macro ARB_ROUND_ROBIN_EN: rotate T->W->R instead of fixed priority R > W > T.
module ncc_mem_arbiter #(
  parameter int unsigned MAX_BURST = 64,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        t_req,
  input  logic [6:0]  t_row,
  input  logic [6:0]  t_col,
  output logic        t_ack,
  input  logic        w_req,
  input  logic [6:0]  w_row,
  input  logic [6:0]  w_col,
  output logic        w_ack,
  input  logic        r_req,
  input  logic [6:0]  r_row,
  input  logic [6:0]  r_col,
  input  logic [31:0] r_data,
  output logic        r_ack,
  output logic        mem_req,
  output logic        mem_rd_wr,
  output logic        mem_tem_win,
  output logic [6:0]  mem_row,
  output logic [6:0]  mem_col,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  output logic [2:0]  grant,
  output logic        timeout_err
);

  typedef enum logic [1:0] {StIdle, StGntT, StGntW, StGntR} state_e;

  localparam logic [8:0] MaxBurst   = 9'(MAX_BURST);
  localparam logic [8:0] TimeoutCnt = 9'(TIMEOUT);

  state_e     state_q, state_d, sel;
  logic [7:0] burst_q, burst_d, wait_q, wait_d;
  logic [2:0] lock_q, lock_d, req_vec, elig, own;
  logic [8:0] burst_inc, wait_inc;
  logic       cur_req, other_pend, abort;

  // Bit order everywhere is {R, W, T}.
  assign req_vec    = {r_req, w_req, t_req};
  assign elig       = req_vec & ~lock_q;
  assign own        = {state_q == StGntR, state_q == StGntW, state_q == StGntT};
  assign grant      = own;
  assign cur_req    = |(req_vec & own);
  assign other_pend = |(elig & ~own);
  assign burst_inc  = {1'b0, burst_q} + 9'd1;
  assign wait_inc   = {1'b0, wait_q} + 9'd1;
  // This granted cycle is the TIMEOUT-th consecutive unacknowledged one.
  assign abort       = (state_q != StIdle) && cur_req && !mem_ack && (wait_inc >= TimeoutCnt);
  assign timeout_err = abort;

`ifdef ARB_ROUND_ROBIN_EN
  state_e last_q, last_d;

  // Pick the first eligible requester after the previous owner in T->W->R order.
  always_comb begin
    sel = StIdle;
    case (last_q)
      StGntT:  sel = elig[1] ? StGntW : elig[2] ? StGntR : elig[0] ? StGntT : StIdle;
      StGntW:  sel = elig[2] ? StGntR : elig[0] ? StGntT : elig[1] ? StGntW : StIdle;
      default: sel = elig[0] ? StGntT : elig[1] ? StGntW : elig[2] ? StGntR : StIdle;
    endcase
  end

  assign last_d = (state_q == StIdle && sel != StIdle) ? sel : last_q;

  // Last-owner register; resets to R so T wins the first rotation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= StGntR;
    else        last_q <= last_d;
  end
`else
  // Fixed priority R > W > T.
  always_comb begin
    sel = elig[2] ? StGntR : elig[1] ? StGntW : elig[0] ? StGntT : StIdle;
  end
`endif

  // Next state, burst/wait counters and abort lock.
  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    wait_d  = wait_q;
    // A lock lasts only while the aborted requester keeps its req high.
    lock_d  = lock_q & req_vec;
    if (state_q == StIdle) begin
      state_d = sel;
    end else if (!cur_req) begin
      state_d = StIdle;
    end else if (mem_ack) begin
      wait_d = '0;
      if (burst_inc >= MaxBurst && other_pend) begin
        state_d = StIdle;
      end else begin
        burst_d = (burst_inc >= MaxBurst) ? MaxBurst[7:0] : burst_inc[7:0];
      end
    end else if (abort) begin
      state_d = StIdle;
      lock_d  = lock_d | own;
    end else begin
      wait_d = wait_inc[7:0];
    end
    if (state_d != state_q) begin
      burst_d = '0;
      wait_d  = '0;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      burst_q <= '0;
      wait_q  <= '0;
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      wait_q  <= wait_d;
      lock_q  <= lock_d;
    end
  end

  // Memory port mux and acks; mem_req depends only on state and the owner's req.
  always_comb begin
    mem_req     = 1'b0;
    mem_rd_wr   = 1'b0;
    mem_tem_win = 1'b0;
    mem_row     = '0;
    mem_col     = '0;
    mem_wdata   = '0;
    t_ack       = 1'b0;
    w_ack       = 1'b0;
    r_ack       = 1'b0;
    case (state_q)
      StGntT: begin
        mem_req = t_req;
        mem_row = t_row;
        mem_col = t_col;
        t_ack   = mem_ack;
      end
      StGntW: begin
        mem_req     = w_req;
        mem_tem_win = 1'b1;
        mem_row     = w_row;
        mem_col     = w_col;
        w_ack       = mem_ack;
      end
      StGntR: begin
        mem_req   = r_req;
        mem_rd_wr = 1'b1;
        mem_row   = r_row;
        mem_col   = r_col;
        mem_wdata = r_data;
        r_ack     = mem_ack;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ncc_mem_arbiter.sv
// Self-checking bench for ncc_mem_arbiter: directed scenarios plus randomized traffic,
// all compared against a cycle-level reference model of the arbitration rules.
module tb_ncc_mem_arbiter;

  localparam int MB = 4;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        t_req = 0, w_req = 0, r_req = 0, mem_ack = 0;
  logic [6:0]  t_row = 0, t_col = 0, w_row = 0, w_col = 0, r_row = 0, r_col = 0;
  logic [31:0] r_data = 0;
  logic        t_ack, w_ack, r_ack, mem_req, mem_rd_wr, mem_tem_win, timeout_err;
  logic [6:0]  mem_row, mem_col;
  logic [31:0] mem_wdata;
  logic [2:0]  grant;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ncc_mem_arbiter #(.MAX_BURST(MB), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .t_req(t_req), .t_row(t_row), .t_col(t_col), .t_ack(t_ack),
    .w_req(w_req), .w_row(w_row), .w_col(w_col), .w_ack(w_ack),
    .r_req(r_req), .r_row(r_row), .r_col(r_col), .r_data(r_data), .r_ack(r_ack),
    .mem_req(mem_req), .mem_rd_wr(mem_rd_wr), .mem_tem_win(mem_tem_win),
    .mem_row(mem_row), .mem_col(mem_col), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .grant(grant), .timeout_err(timeout_err)
  );

  // Reference model: owner 0=none, 1=T, 2=W, 3=R.
  int          m_own, m_burst, m_wait, m_last;
  logic [3:1]  m_lock;
  logic [55:0] exp_vec;

  function automatic logic [55:0] dut_vec();
    return {grant, r_ack, w_ack, t_ack, mem_req, mem_rd_wr, mem_tem_win,
            mem_row, mem_col, mem_wdata, timeout_err};
  endfunction

  task automatic model_reset();
    m_own = 0; m_burst = 0; m_wait = 0; m_last = 3; m_lock = '0;
  endtask

  function automatic int pick(logic [3:1] el);
`ifdef ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= 3; k++) begin
      int c;
      c = ((m_last - 1 + k) % 3) + 1;
      if (el[c]) return c;
    end
`else
    for (int i = 3; i >= 1; i--) if (el[i]) return i;
`endif
    return 0;
  endfunction

  task automatic model_eval();
    logic [2:0] g, a;
    logic mreq, rw, tw, te;
    logic [6:0] row, col;
    logic [31:0] wd;
    if (!rst_n) model_reset();
    g = 0; a = 0; mreq = 0; rw = 0; tw = 0; row = 0; col = 0; wd = 0;
    if (m_own == 1) begin g = 3'b001; mreq = t_req; row = t_row; col = t_col; end
    if (m_own == 2) begin g = 3'b010; mreq = w_req; row = w_row; col = w_col; tw = 1; end
    if (m_own == 3) begin
      g = 3'b100; mreq = r_req; row = r_row; col = r_col; rw = 1; wd = r_data;
    end
    if (mem_ack) a = g;
    te = (m_own != 0) && mreq && !mem_ack && (m_wait + 1 >= TO);
    exp_vec = {g, a, mreq, rw, tw, row, col, wd, te};
  endtask

  task automatic model_next();
    logic [3:1] rq, el;
    logic other, ab;
    int c;
    if (!rst_n) begin model_reset(); return; end
    rq = {r_req, w_req, t_req};
    el = rq & ~m_lock;
    c = m_own;
    ab = 0;
    if (m_own == 0) begin
      c = pick(el);
      if (c != 0) m_last = c;
    end else begin
      other = 0;
      for (int i = 1; i <= 3; i++) if (i != m_own && el[i]) other = 1;
      if (!rq[m_own]) c = 0;
      else if (mem_ack) begin
        m_wait = 0;
        if (m_burst + 1 >= MB && other) c = 0;
        else m_burst = (m_burst + 1 > MB) ? MB : m_burst + 1;
      end else if (m_wait + 1 >= TO) begin
        c = 0; ab = 1;
      end else m_wait++;
    end
    for (int i = 1; i <= 3; i++) if (!rq[i]) m_lock[i] = 0;
    if (ab) m_lock[m_own] = 1;
    if (c != m_own) begin m_burst = 0; m_wait = 0; end
    m_own = c;
  endtask

  task automatic settle();
    @(negedge clk);
    model_eval();
  endtask

  task automatic advance();
    @(posedge clk);
    model_next();
    #1;
  endtask

  task automatic idle_inputs();
    t_req = 0; w_req = 0; r_req = 0; mem_ack = 0;
  endtask

  task automatic drain();
    idle_inputs();
    repeat (3) begin settle(); advance(); end
  endtask

  task automatic test_reset();
    for (int cyc = 0; cyc < 4; cyc++) begin
      {t_req, w_req, r_req, mem_ack} = 4'($urandom);
      t_row = 7'($urandom); w_row = 7'($urandom); r_row = 7'($urandom);
      r_data = $urandom;
      settle();
      checks++;
      if (dut_vec() !== exp_vec) begin
        failures++;
        $display("FAIL reset_outputs cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec);
      end
      checks++;
      if (grant !== 3'b000 || mem_req !== 1'b0) begin
        failures++;
        $display("FAIL reset_grant got=%b/%b exp=000/0", grant, mem_req);
      end
      advance();
    end
    idle_inputs();
    rst_n = 1'b1;
    settle(); advance();
  endtask

  task automatic test_single_t();
    int acks = 0;
    t_req = 1; mem_ack = 1; t_row = 7'd12; t_col = 7'd34;
    for (int cyc = 0; cyc <= 18; cyc++) begin
      if (cyc == 17) begin t_req = 0; mem_ack = 0; end
      settle();
      checks++;
      if (dut_vec() !== exp_vec) begin
        failures++;
        $display("FAIL single_t cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec);
      end
      if (t_ack) begin
        acks++;
        checks++;
        if (mem_tem_win !== 1'b0) begin
          failures++;
          $display("FAIL single_t_temwin cyc=%0d got=%b exp=0", cyc, mem_tem_win);
        end
      end
      if (cyc == 1) begin
        checks++;
        if (grant !== 3'b001) begin
          failures++;
          $display("FAIL single_t_grant got=%b exp=001", grant);
        end
      end
      if (cyc == 18) begin
        checks++;
        if (grant !== 3'b000) begin
          failures++;
          $display("FAIL single_t_idle got=%b exp=000", grant);
        end
      end
      advance();
    end
    checks++;
    if (acks != 16) begin
      failures++;
      $display("FAIL single_t_ack_count got=%0d exp=16", acks);
    end
    drain();
  endtask

  task automatic test_priority();
    t_req = 1; r_req = 1; mem_ack = 0; r_data = $urandom; r_row = 7'd5; r_col = 7'd9;
    for (int cyc = 0; cyc <= 5; cyc++) begin
      if (cyc == 2) begin r_req = 0; mem_ack = 1; end
      if (cyc == 3) mem_ack = 0;
      settle();
      checks++;
      if (dut_vec() !== exp_vec) begin
        failures++;
        $display("FAIL priority cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec);
      end
      if (cyc == 1) begin
        checks++;
        if (grant !== 3'b100 || mem_rd_wr !== 1'b1 || mem_wdata !== r_data) begin
          failures++;
          $display("FAIL priority_r got=%b/%b/%h exp=100/1/%h", grant, mem_rd_wr, mem_wdata,
                   r_data);
        end
      end
      if (cyc == 2) begin
        checks++;
        if (r_ack !== 1'b1) begin
          failures++;
          $display("FAIL priority_last_beat got=%b exp=1", r_ack);
        end
      end
      if (cyc == 3 || cyc == 4) begin
        checks++;
        if (grant !== ((cyc == 3) ? 3'b000 : 3'b001)) begin
          failures++;
          $display("FAIL priority_bubble cyc=%0d got=%b", cyc, grant);
        end
      end
      advance();
    end
    drain();
  endtask

  task automatic test_burst_limit();
    int acks = 0;
    w_req = 1; mem_ack = 1;
    for (int cyc = 0; cyc <= 7; cyc++) begin
      if (cyc == 1) t_req = 1;
`ifndef ARB_ROUND_ROBIN_EN
      if (cyc == 5) w_req = 0;
`endif
      settle();
      checks++;
      if (dut_vec() !== exp_vec) begin
        failures++;
        $display("FAIL burst cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec);
      end
      if (w_ack) acks++;
      if (cyc == 5 || cyc == 6) begin
        checks++;
        if (grant !== ((cyc == 5) ? 3'b000 : 3'b001)) begin
          failures++;
          $display("FAIL burst_release cyc=%0d got=%b", cyc, grant);
        end
      end
      advance();
    end
    checks++;
    if (acks != MB) begin
      failures++;
      $display("FAIL burst_ack_count got=%0d exp=%0d", acks, MB);
    end
    drain();
  endtask

  task automatic test_timeout();
    t_req = 1; mem_ack = 0;
    for (int cyc = 0; cyc <= 15; cyc++) begin
      if (cyc == 12) t_req = 0;
      if (cyc == 13) t_req = 1;
      settle();
      checks++;
      if (dut_vec() !== exp_vec) begin
        failures++;
        $display("FAIL timeout cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec);
      end
      if (cyc == 7 || cyc == 8) begin
        checks++;
        if (timeout_err !== (cyc == 8)) begin
          failures++;
          $display("FAIL timeout_pulse cyc=%0d got=%b", cyc, timeout_err);
        end
      end
      if (cyc == 11 || cyc == 14) begin
        checks++;
        if (grant !== ((cyc == 11) ? 3'b000 : 3'b001)) begin
          failures++;
          $display("FAIL timeout_lock cyc=%0d got=%b", cyc, grant);
        end
      end
      advance();
    end
    drain();
  endtask

  task automatic test_rotation();
    int seq[4];
    int exp_seq[4];
    int n = 0;
    logic [2:0] prev = 3'b000;
`ifdef ARB_ROUND_ROBIN_EN
    exp_seq = '{1, 2, 3, 1};
`else
    exp_seq = '{3, 3, 3, 3};
`endif
    for (int cyc = 0; cyc < 24 && n < 4; cyc++) begin
      t_req = (m_own != 1); w_req = (m_own != 2); r_req = (m_own != 3);
      mem_ack = (m_own != 0);
      settle();
      checks++;
      if (dut_vec() !== exp_vec) begin
        failures++;
        $display("FAIL rotation cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec);
      end
      if (prev == 3'b000 && grant != 3'b000) begin
        seq[n] = grant[2] ? 3 : grant[1] ? 2 : 1;
        n++;
      end
      prev = grant;
      advance();
    end
    checks++;
    if (n != 4) begin
      failures++;
      $display("FAIL rotation_count got=%0d exp=4", n);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (seq[i] != exp_seq[i]) begin
          failures++;
          $display("FAIL rotation_order idx=%0d got=%0d exp=%0d", i, seq[i], exp_seq[i]);
        end
      end
    end
    drain();
  endtask

  task automatic test_reset_mid_burst();
    w_req = 1; mem_ack = 1; w_row = 7'd77; w_col = 7'd3;
    for (int cyc = 0; cyc <= 7; cyc++) begin
      if (cyc == 3) #2 rst_n = 1'b0;
      if (cyc == 5) rst_n = 1'b1;
      settle();
      checks++;
      if (dut_vec() !== exp_vec) begin
        failures++;
        $display("FAIL reset_mid cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec);
      end
      if (cyc == 3) begin
        checks++;
        if (w_ack !== 1'b0 || mem_req !== 1'b0 || grant !== 3'b000 || mem_row !== 7'd0) begin
          failures++;
          $display("FAIL reset_mid_outputs got=%b/%b/%b/%h exp=0/0/000/00", w_ack, mem_req,
                   grant, mem_row);
        end
      end
      if (cyc == 6) begin
        checks++;
        if (grant !== 3'b010) begin
          failures++;
          $display("FAIL reset_mid_regrant got=%b exp=010", grant);
        end
      end
      advance();
    end
    drain();
  endtask

  task automatic test_random();
    int ack_pct;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      ack_pct = ((cyc / 300) % 2 == 0) ? 60 : 5;
      if ($urandom_range(7, 0) == 0) t_req = ~t_req;
      if ($urandom_range(7, 0) == 0) w_req = ~w_req;
      if ($urandom_range(7, 0) == 0) r_req = ~r_req;
      mem_ack = ($urandom_range(99, 0) < ack_pct);
      t_row = 7'($urandom); t_col = 7'($urandom);
      w_row = 7'($urandom); w_col = 7'($urandom);
      r_row = 7'($urandom); r_col = 7'($urandom); r_data = $urandom;
      settle();
      checks++;
      if (dut_vec() !== exp_vec) begin
        failures++;
        $display("FAIL random cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec);
      end
      advance();
    end
    drain();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_t();
    test_priority();
    test_burst_limit();
    test_timeout();
    test_rotation();
    test_reset_mid_burst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
